// File: rtl/ddr_tx_pkg.sv
// Shared types and sizing helpers for the DDR TX gearbox.
// State encodings plus FIFO pointer/fill width functions.
package ddr_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int fill_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/ddr_tx_gearbox_if.sv
// Valid/ready word stream into the gearbox.
// master drives S_DATA/S_VALID, slave returns S_READY.
interface ddr_tx_gearbox_if #(
  parameter int LANES = 12
) ();

  logic [2*LANES-1:0] S_DATA;
  logic               S_VALID;
  logic               S_READY;

  modport master (
    output S_DATA,
    output S_VALID,
    input  S_READY
  );

  modport slave (
    input  S_DATA,
    input  S_VALID,
    output S_READY
  );

endinterface

// File: rtl/ddr_tx_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally.
// Ports: push/pop/flush/data in; head/full/empty/fill out.
module ddr_tx_fifo
  import ddr_tx_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [WIDTH-1:0]          data_i,
  output logic [WIDTH-1:0]          head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [fill_w(DEPTH)-1:0]  fill_o
);

  localparam int AW = ptr_w(DEPTH);
  localparam int FW = fill_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [FW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign fill_o  = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case (1'b1)
        (do_push && !do_pop): cnt_d = cnt_q + FW'(1);
        (do_pop && !do_push): cnt_d = cnt_q - FW'(1);
        default:              cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/ddr_tx_gearbox.sv
// Feeds per-pin same-edge ODDRs: training, then streamed D0/D1 pairs.
// Ports: CLK/RSTN/EN, stream slave S, D0/D1, LOCKED, UNDERFLOW, FILL.
module ddr_tx_gearbox
  import ddr_tx_pkg::*;
#(
  parameter int   LANES        = 12,
  parameter int   FIFO_DEPTH   = 4,
  parameter int   TRAIN_CYCLES = 64,
  parameter logic TRAIN_D0     = 1'b1,
  parameter logic TRAIN_D1     = 1'b0,
  parameter logic IDLE_VALUE   = 1'b0
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          EN,
  ddr_tx_gearbox_if.slave               S,
  output logic [LANES-1:0]              D0,
  output logic [LANES-1:0]              D1,
  output logic                          LOCKED,
  output logic                          UNDERFLOW,
  output logic [fill_w(FIFO_DEPTH)-1:0] FILL
);

  localparam int CW = $clog2(TRAIN_CYCLES + 1);
  localparam logic [LANES-1:0] IDLE_W = {LANES{IDLE_VALUE}};
  localparam logic [LANES-1:0] TR_D0  = {LANES{TRAIN_D0}};
  localparam logic [LANES-1:0] TR_D1  = {LANES{TRAIN_D1}};

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0] d0_q, d0_d;
  logic [LANES-1:0] d1_q, d1_d;
  logic             locked_q, locked_d;
  logic             uf_q, uf_d;

  logic [2*LANES-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Ready looks only at registered state, never at a same-cycle pop.
  assign S.S_READY = (state_q != ST_IDLE) && !full;
  assign push      = S.S_VALID && S.S_READY;

  ddr_tx_fifo #(
    .WIDTH (2*LANES),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (!EN),
    .data_i  (S.S_DATA),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (FILL)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    locked_d = locked_q;
    uf_d     = uf_q;
    pop      = 1'b0;
    if (!EN) begin
      state_d  = ST_IDLE;
      d0_d     = IDLE_W;
      d1_d     = IDLE_W;
      locked_d = 1'b0;
      uf_d     = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          d0_d    = IDLE_W;
          d1_d    = IDLE_W;
          cnt_d   = '0;
          state_d = ST_TRAIN;
        end
        (state_q == ST_TRAIN): begin
          d0_d  = TR_D0;
          d1_d  = TR_D1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TRAIN_CYCLES - 1)) begin
            state_d  = ST_RUN;
            locked_d = 1'b1;
          end
        end
        (state_q == ST_RUN): begin
          if (!empty) begin
            pop  = 1'b1;
            d0_d = head[LANES-1:0];
            d1_d = head[2*LANES-1:LANES];
          end else begin
            d0_d = IDLE_W;
            d1_d = IDLE_W;
            uf_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          d0_d    = IDLE_W;
          d1_d    = IDLE_W;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      d0_q     <= IDLE_W;
      d1_q     <= IDLE_W;
      locked_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      locked_q <= locked_d;
      uf_q     <= uf_d;
    end
  end

  assign D0        = d0_q;
  assign D1        = d1_q;
  assign LOCKED    = locked_q;
  assign UNDERFLOW = uf_q;

endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// Directed bench for ddr_tx_gearbox with a word scoreboard.
// Expected D0/D1 come from words queued at acceptance.
module tb_ddr_tx_gearbox;

  localparam int LANES = 12;
  localparam int DEPTH = 4;
  localparam int TRN   = 8;

  logic              CLK;
  logic              RSTN;
  logic              EN;
  logic [LANES-1:0]  D0;
  logic [LANES-1:0]  D1;
  logic              LOCKED;
  logic              UNDERFLOW;
  logic [2:0]        FILL;

  ddr_tx_gearbox_if #(.LANES(LANES)) s_if ();

  ddr_tx_gearbox #(
    .LANES        (LANES),
    .FIFO_DEPTH   (DEPTH),
    .TRAIN_CYCLES (TRN),
    .TRAIN_D0     (1'b1),
    .TRAIN_D1     (1'b0),
    .IDLE_VALUE   (1'b0)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .EN        (EN),
    .S         (s_if.slave),
    .D0        (D0),
    .D1        (D1),
    .LOCKED    (LOCKED),
    .UNDERFLOW (UNDERFLOW),
    .FILL      (FILL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // reference: abstract behaviour + scoreboard of accepted words
  int               m_state = 0;
  int               m_cnt   = 0;
  logic [LANES-1:0] m_d0    = '0;
  logic [LANES-1:0] m_d1    = '0;
  logic             m_lock  = 1'b0;
  logic             m_uf    = 1'b0;
  logic [23:0]      sb[$];
  logic             acc;
  int               tcount;
  int               wn;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // one clock: check ready, clock, update model, check outputs
  task automatic step();
    logic        rdy;
    logic [23:0] w;
    rdy = (m_state != 0) && (sb.size() < DEPTH);
    chk("s_ready", {31'b0, s_if.S_READY}, {31'b0, rdy});
    acc = RSTN && EN && s_if.S_VALID && rdy;
    w   = s_if.S_DATA;
    @(posedge CLK);
    if (!RSTN || !EN) begin
      m_state = 0;
      if (!RSTN) m_cnt = 0;
      sb.delete();
      m_d0 = '0; m_d1 = '0;
      m_lock = 1'b0; m_uf = 1'b0;
    end else begin
      case (m_state)
        0: begin
          m_state = 1; m_cnt = 0;
          m_d0 = '0; m_d1 = '0;
        end
        1: begin
          m_d0 = '1; m_d1 = '0;
          if (m_cnt == TRN - 1) begin
            m_state = 2; m_lock = 1'b1;
          end
          m_cnt++;
        end
        default: begin
          if (sb.size() > 0) begin
            logic [23:0] h;
            h = sb.pop_front();
            m_d0 = h[11:0]; m_d1 = h[23:12];
          end else begin
            m_d0 = '0; m_d1 = '0; m_uf = 1'b1;
          end
        end
      endcase
      if (acc) sb.push_back(w);
    end
    #1;
    chk("d0", {20'b0, D0}, {20'b0, m_d0});
    chk("d1", {20'b0, D1}, {20'b0, m_d1});
    chk("locked", {31'b0, LOCKED}, {31'b0, m_lock});
    chk("underflow", {31'b0, UNDERFLOW}, {31'b0, m_uf});
    chk("fill", {29'b0, FILL}, 32'(sb.size()));
    if (D0 === 12'hFFF && D1 === 12'h000) tcount++;
  endtask

  function automatic logic [23:0] gen(input int n);
    return {12'(n * 37 + 5), 12'(n * 91 + 3)};
  endfunction

  initial begin
    RSTN = 1'b0;
    EN   = 1'b0;
    s_if.S_VALID = 1'b0;
    s_if.S_DATA  = '0;
    @(posedge CLK);
    #1;
    // reset / idle
    repeat (3) step();
    chk("rst_d0", {20'b0, D0}, 32'h0);
    RSTN = 1'b1;
    step();

    // training then three back-to-back words
    EN = 1'b1;
    tcount = 0;
    repeat (TRN) step();
    s_if.S_VALID = 1'b1;
    s_if.S_DATA  = 24'hA5A_5A5;
    step();
    chk("train_len", tcount, TRN);
    chk("locked_up", {31'b0, LOCKED}, 32'h1);
    s_if.S_DATA = 24'h123_456;
    step();
    chk("first_d0", {20'b0, D0}, 32'h5A5);
    s_if.S_DATA = 24'hFFF_000;
    step();
    chk("second_d1", {20'b0, D1}, 32'h123);
    s_if.S_VALID = 1'b0;
    step();
    chk("third_d0", {20'b0, D0}, 32'h000);
    chk("no_uf_yet", {31'b0, UNDERFLOW}, 32'h0);
    step();
    step();
    chk("uf_set", {31'b0, UNDERFLOW}, 32'h1);
    // resume
    s_if.S_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_if.S_DATA = gen(100 + i);
      step();
    end
    s_if.S_VALID = 1'b0;
    repeat (3) step();
    chk("uf_sticky", {31'b0, UNDERFLOW}, 32'h1);

    // disable, then prefill during training and stream across wraps
    EN = 1'b0;
    step();
    EN = 1'b1;
    s_if.S_VALID = 1'b1;
    wn = 0;
    s_if.S_DATA = gen(wn);
    for (int i = 0; i < TRN + 1 + 24; i++) begin
      step();
      if (acc) begin
        wn++;
        s_if.S_DATA = gen(wn);
      end
    end
    chk("wrap_words", 32'(wn >= 24), 32'h1);
    chk("fill3", {29'b0, FILL}, 32'h3);

    // disable mid-stream with valid held high
    EN = 1'b0;
    step();
    chk("dis_fill", {29'b0, FILL}, 32'h0);
    chk("dis_lock", {31'b0, LOCKED}, 32'h0);
    chk("dis_uf", {31'b0, UNDERFLOW}, 32'h0);

    // re-enable reruns the full training
    s_if.S_VALID = 1'b0;
    EN = 1'b1;
    tcount = 0;
    repeat (TRN + 1) step();
    chk("retrain_len", tcount, TRN);
    repeat (2) step();
    chk("re_uf", {31'b0, UNDERFLOW}, 32'h1);

    // reset mid-stream overrides EN
    RSTN = 1'b0;
    step();
    chk("rst_lock", {31'b0, LOCKED}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_tx_gearbox.md
# ddr_tx_gearbox

Upstream feeder for a bank of per-pin DDR output registers (one ODDR per pin, configured with DDR_CLK_EDGE=1, same-edge capture) driving the scaler's parallel video output bus. The block accepts 2×LANES-bit words over a valid/ready stream and buffers them in a small FIFO. Every clock it emits one D0/D1 lane pair: first a fixed training pattern after enable, then streamed data. It inserts an idle value and raises a sticky flag on underflow.

## Interface
Parameters:
- LANES, 12, output pins; D0/D1 width
- FIFO_DEPTH, 4, buffer entries; power of two, ≥2
- TRAIN_CYCLES, 64, cycles of training pattern after enable; ≥1
- TRAIN_D0, 1'b1, training bit replicated on all D0 lanes
- TRAIN_D1, 1'b0, training bit replicated on all D1 lanes
- IDLE_VALUE, 1'b0, idle bit replicated on all D0/D1 lanes

Ports:
- CLK  in  1  single clock; also clocks the downstream ODDRs
- RSTN  in  1  reset, synchronous, active-low
- EN  in  1  link enable; level-sensitive
- S_DATA  in  2×LANES  [LANES-1:0] → D0 (high-clock half), [2×LANES-1:LANES] → D1 (low-clock half)
- S_VALID  in  1  S_DATA valid
- S_READY  out  1  block can accept
- D0  out  LANES  to ODDR D0 inputs, registered
- D1  out  LANES  to ODDR D1 inputs, registered
- LOCKED  out  1  high while in RUN
- UNDERFLOW  out  1  sticky: FIFO empty during RUN
- FILL  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset (RSTN=0 at an edge): state IDLE; FIFO pointers 0; D0=D1={LANES{IDLE_VALUE}}; LOCKED=0; UNDERFLOW=0; FILL=0; train counter 0.
- S_READY = (state≠IDLE) && (FILL<FIFO_DEPTH), combinational from registers only.
- Push when S_VALID && S_READY. S_READY does not depend on a same-cycle pop, so a full FIFO never accepts.
- States:
  - IDLE: D←idle. On EN=1: →TRAIN, counter←0.
  - TRAIN: D0←{LANES{TRAIN_D0}}, D1←{LANES{TRAIN_D1}}, counter++. The FIFO may fill, but nothing is popped. When counter==TRAIN_CYCLES-1: →RUN, LOCKED←1.
  - RUN: if FIFO not empty, D0/D1←head halves and pop. Otherwise D←idle and UNDERFLOW←1.
- EN=0 in any state (checked before other transitions): →IDLE, FIFO flushed (pointers 0), D←idle, LOCKED←0, UNDERFLOW←0. Any S_VALID in that cycle is dropped.
- UNDERFLOW stays set until reset or EN=0. Streaming continues normally once data resumes.
- Simultaneous push and pop in RUN: FILL unchanged. Pointers wrap modulo FIFO_DEPTH.
- FILL is updated on the same edge as push/pop.

## Timing
- All outputs except S_READY are registered.
- EN rises before edge k: training on D from after edge k+1 through exactly TRAIN_CYCLES cycles. LOCKED rises after edge k+TRAIN_CYCLES. The first data pop is at edge k+TRAIN_CYCLES+1.
- RUN latency: word accepted at edge t into an empty FIFO appears on D0/D1 after edge t+1.
- Sustained throughput: one word per clock. S_READY stays high indefinitely with continuous S_VALID in RUN.
- The ODDR adds its own half-cycle stage; D0 must reach the pin during high CLK and D1 during low CLK of the following cycle.
- RSTN asserted mid-stream takes effect at the next edge and overrides EN.

## Structure
- Shared package/include `ddr_tx_pkg`: state encodings (IDLE=2'd0, TRAIN=2'd1, RUN=2'd2), pointer/FILL width function (clog2).
- One sub-module: `ddr_tx_fifo`, a synchronous FIFO with parameters WIDTH and DEPTH.
  - Inputs: push, pop, flush.
  - Outputs: head data, full, empty, fill.
  - Sync active-low reset.
- The top holds the FSM, train counter, and output registers.

## Test plan
- Reset/idle: hold RSTN=0 3 cycles, EN=0 → D0=D1=0, LOCKED=0, S_READY=0, FILL=0.
- Training: TRAIN_CYCLES=8, EN=1 at edge k → D0=12'hFFF, D1=12'h000 for exactly 8 cycles. LOCKED=1 after edge k+8. While S_VALID=1, S_READY drops when FILL=4.
- Streaming: push 24'hA5A_5A5, 24'h123_456, 24'hFFF_000 back-to-back in RUN → D0/D1 = 5A5/A5A, 456/123, 000/FFF on consecutive cycles, each one cycle after acceptance. UNDERFLOW stays 0.
- Underflow: stop S_VALID for 2 cycles in RUN → D=0 for 2 cycles, UNDERFLOW=1 and stays 1. Resumed data streams correctly.
- Full/wrap: pre-fill 4 words during TRAIN, then 20 continuous words → output order exact across pointer wraps; FILL never exceeds 4.
- Disable mid-stream: EN=0 with FILL=3 → next cycle IDLE, FILL=0, D=0, LOCKED=0, UNDERFLOW=0. Re-enable reruns full training.
